// File: rtl/vme_master_seq_if.sv
// Upstream command handshake plus VME A24/D16 bus lines of the master sequencer.
// master = sequencer side, slave = command source / VME slave side.
interface vme_master_seq_if;
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [22:0] vme_addr;
    logic [5:0]  vme_am;
    logic        vme_as_b;
    logic        vme_ds0_b;
    logic        vme_ds1_b;
    logic        vme_write_b;
    logic [15:0] vme_data_out;
    logic        vme_data_oe;
    logic [15:0] vme_data_in;
    logic        vme_dtack_b;
    logic        vme_berr_b;

    modport master (
        input  start, vme_cmd_reg, vme_dat_reg_in, vme_data_in, vme_dtack_b, vme_berr_b,
        output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, vme_addr, vme_am, vme_as_b,
               vme_ds0_b, vme_ds1_b, vme_write_b, vme_data_out, vme_data_oe
    );

    modport slave (
        output start, vme_cmd_reg, vme_dat_reg_in, vme_data_in, vme_dtack_b, vme_berr_b,
        input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, vme_addr, vme_am, vme_as_b,
               vme_ds0_b, vme_ds1_b, vme_write_b, vme_data_out, vme_data_oe
    );
endinterface

// File: rtl/vme_master_seq.sv
// VME A24/D16 master: one bus cycle per accepted command word; optional no-response timeout under VME_TIMEOUT_EN.
// Latency: SETUP_CYC+8 clocks from start to vme_dat_wr when the slave answers immediately.
// Backpressure: vme_cmd_rd is low for the whole bus cycle; start is ignored while it is low.
module vme_master_seq #(
    parameter int       SETUP_CYC   = 2,
    parameter int       TIMEOUT_CYC = 1024,
    parameter bit [5:0] AM_CODE     = 6'h39
) (
    input  logic              clk,
    input  logic              rst_n,
    vme_master_seq_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        WAIT,
        RELEASE,
        DONE
    } state_t;

    state_t      state_q, state_nx;
    logic [3:0]  scnt_q, scnt_nx;
    logic        is_rd_q, is_rd_nx;
    // {berr, timeout, data}: result staged here until DONE publishes it
    logic [17:0] res_q, res_nx;
    logic        as_q, as_nx;
    logic        ds_q, ds_nx;
    logic        wr_q, wr_nx;
    logic [22:0] addr_q, addr_nx;
    logic [15:0] dout_q, dout_nx;
    logic        oe_q, oe_nx;
    logic        cmd_rd_q, cmd_rd_nx;
    logic        dat_wr_q, dat_wr_nx;
    logic [31:0] dro_q, dro_nx;

    logic        dtack_m, dtack_s;
    logic        berr_m, berr_s;

`ifdef VME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tcnt_q, tcnt_nx;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.vme_cmd_reg[31:26], bus.vme_cmd_reg[24], bus.vme_cmd_reg[0],
                           bus.vme_dat_reg_in[31:16]};

    // slave responses are asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dtack_m <= 1'b1;
            dtack_s <= 1'b1;
            berr_m  <= 1'b1;
            berr_s  <= 1'b1;
        end else begin
            dtack_m <= bus.vme_dtack_b;
            dtack_s <= dtack_m;
            berr_m  <= bus.vme_berr_b;
            berr_s  <= berr_m;
        end
    end

    always_comb begin
        state_nx  = state_q;
        scnt_nx   = scnt_q;
        is_rd_nx  = is_rd_q;
        res_nx    = res_q;
        as_nx     = as_q;
        ds_nx     = ds_q;
        wr_nx     = wr_q;
        addr_nx   = addr_q;
        dout_nx   = dout_q;
        oe_nx     = oe_q;
        cmd_rd_nx = cmd_rd_q;
        dat_wr_nx = 1'b0;
        dro_nx    = dro_q;
`ifdef VME_TIMEOUT_EN
        tcnt_nx   = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_rd_nx = 1'b1;
                if (cmd_rd_q && bus.start) begin
                    is_rd_nx  = bus.vme_cmd_reg[25];
                    addr_nx   = bus.vme_cmd_reg[23:1];
                    wr_nx     = bus.vme_cmd_reg[25];
                    if (!bus.vme_cmd_reg[25]) begin
                        dout_nx = bus.vme_dat_reg_in[15:0];
                        oe_nx   = 1'b1;
                    end
                    scnt_nx   = 4'd0;
                    cmd_rd_nx = 1'b0;
                    state_nx  = ADDR;
                end
            end
            ADDR: begin
                if (scnt_q == 4'(SETUP_CYC - 1)) begin
                    as_nx    = 1'b0;
                    state_nx = STROBE;
                end else begin
                    scnt_nx = scnt_q + 4'd1;
                end
            end
            STROBE: begin
                ds_nx    = 1'b0;
`ifdef VME_TIMEOUT_EN
                tcnt_nx  = '0;
`endif
                state_nx = WAIT;
            end
            WAIT: begin
                if (!berr_s) begin
                    res_nx   = {2'b10, 16'h0000};
                    state_nx = RELEASE;
                end else if (!dtack_s) begin
                    res_nx   = {2'b00, is_rd_q ? bus.vme_data_in : dout_q};
                    state_nx = RELEASE;
                end
`ifdef VME_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    res_nx   = {2'b01, 16'h0000};
                    state_nx = RELEASE;
                end else begin
                    tcnt_nx = tcnt_q + TW'(1);
                end
                if (state_nx == RELEASE) tcnt_nx = '0;
`endif
                if (state_nx == RELEASE) begin
                    as_nx = 1'b1;
                    ds_nx = 1'b1;
                    oe_nx = 1'b0;
                end
            end
            RELEASE: begin
                if (dtack_s && berr_s) begin
                    state_nx = DONE;
                end
`ifdef VME_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_nx = DONE;
                end else begin
                    tcnt_nx = tcnt_q + TW'(1);
                end
`endif
                if (state_nx == DONE) begin
                    dat_wr_nx = 1'b1;
                    dro_nx    = {14'd0, res_q};
                end
            end
            DONE: begin
                cmd_rd_nx = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            scnt_q   <= 4'd0;
            is_rd_q  <= 1'b0;
            res_q    <= '0;
            as_q     <= 1'b1;
            ds_q     <= 1'b1;
            wr_q     <= 1'b1;
            addr_q   <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            cmd_rd_q <= 1'b0;
            dat_wr_q <= 1'b0;
            dro_q    <= '0;
`ifdef VME_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_nx;
            scnt_q   <= scnt_nx;
            is_rd_q  <= is_rd_nx;
            res_q    <= res_nx;
            as_q     <= as_nx;
            ds_q     <= ds_nx;
            wr_q     <= wr_nx;
            addr_q   <= addr_nx;
            dout_q   <= dout_nx;
            oe_q     <= oe_nx;
            cmd_rd_q <= cmd_rd_nx;
            dat_wr_q <= dat_wr_nx;
            dro_q    <= dro_nx;
`ifdef VME_TIMEOUT_EN
            tcnt_q   <= tcnt_nx;
`endif
        end
    end

    assign bus.vme_cmd_rd      = cmd_rd_q;
    assign bus.vme_dat_wr      = dat_wr_q;
    assign bus.vme_dat_reg_out = dro_q;
    assign bus.vme_addr        = addr_q;
    assign bus.vme_am          = AM_CODE;
    assign bus.vme_as_b        = as_q;
    assign bus.vme_ds0_b       = ds_q;
    assign bus.vme_ds1_b       = ds_q;
    assign bus.vme_write_b     = wr_q;
    assign bus.vme_data_out    = dout_q;
    assign bus.vme_data_oe     = oe_q;

endmodule

// File: tb/tb_vme_master_seq.sv
// Randomized bench for vme_master_seq: a negedge-driven VME slave plus a transaction-level model of
// the expected address, direction, result word and cycle timing.
module tb_vme_master_seq;

    localparam int SETUP = 2;
`ifdef VME_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vme_master_seq_if bus ();

    vme_master_seq #(
        .SETUP_CYC   (SETUP),
        .TIMEOUT_CYC (TO),
        .AM_CODE     (6'h39)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave: answers d clocks after both data strobes go low; 0=dtack 1=berr 2=both 3=silent
    int          rsp_delay = 1;
    int          rsp_mode  = 0;
    logic [15:0] rsp_data  = 16'h0;
    int          ds_cnt    = 0;

    always @(negedge clk) begin
        if (bus.vme_ds0_b == 1'b0 && bus.vme_ds1_b == 1'b0) begin
            ds_cnt++;
            if (rsp_mode != 3 && ds_cnt >= rsp_delay) begin
                if (rsp_mode != 0) bus.vme_berr_b = 1'b0;
                if (rsp_mode != 1) bus.vme_dtack_b = 1'b0;
                bus.vme_data_in = rsp_data;
            end
        end else begin
            ds_cnt          = 0;
            bus.vme_dtack_b = 1'b1;
            bus.vme_berr_b  = 1'b1;
            bus.vme_data_in = 16'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pins();
        return {bus.vme_as_b, bus.vme_ds0_b, bus.vme_ds1_b, bus.vme_write_b, bus.vme_data_oe};
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!bus.vme_cmd_rd && w < 50) begin
            tick();
            w++;
        end
        chk("cmd_rd_ready", {31'd0, bus.vme_cmd_rd}, 32'd1);
    endtask

    // Expected timing: AS falls SETUP clocks after the address, DS one clock later; the response
    // then crosses the 2-flop synchroniser, the release crosses it again, then the DONE pulse.
    task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] dat, input int d,
                           input int mode, input logic [15:0] sdata);
        logic        rd;
        logic [31:0] exp_res, prev;
        int          exp_lat, exp_ds, k, as_k, ds_k, ds_n;
        bit          unstable, oe_bad, wr_bad;
        rd      = cmd[25];
        exp_res = (mode == 1 || mode == 2) ? 32'h0002_0000 :
                  (mode == 3) ? 32'h0001_0000 :
                  rd ? {16'h0, sdata} : {16'h0, dat[15:0]};
        exp_lat = (mode == 3) ? SETUP + 3 + TO : SETUP + 7 + d;
        exp_ds  = (mode == 3) ? TO : d + 2;
        rsp_delay = d;
        rsp_mode  = mode;
        rsp_data  = sdata;
        wait_ready();
        prev = bus.vme_dat_reg_out;
        bus.start          = 1'b1;
        bus.vme_cmd_reg    = cmd;
        bus.vme_dat_reg_in = dat;
        tick();
        bus.start = 1'b0;
        chk("addr", {9'd0, bus.vme_addr}, {9'd0, cmd[23:1]});
        chk("write_b", {31'd0, bus.vme_write_b}, {31'd0, rd});
        chk("oe", {31'd0, bus.vme_data_oe}, {31'd0, ~rd});
        chk("cmd_rd_low", {31'd0, bus.vme_cmd_rd}, 32'd0);
        if (!rd) chk("data_out", {16'd0, bus.vme_data_out}, {16'd0, dat[15:0]});
        as_k = -1; ds_k = -1; ds_n = 0;
        unstable = 0; oe_bad = 0; wr_bad = 0;
        for (k = 1; k < 300; k++) begin
            if (k > 1) tick();
            if (bus.vme_dat_wr) break;
            if (bus.vme_as_b == 1'b0 && as_k < 0) as_k = k;
            if (bus.vme_ds0_b == 1'b0 && bus.vme_ds1_b == 1'b0) begin
                if (ds_k < 0) ds_k = k;
                ds_n++;
            end
            if (bus.vme_dat_reg_out !== prev) unstable = 1;
            if (rd && bus.vme_data_oe) oe_bad = 1;
            if (bus.vme_write_b !== rd) wr_bad = 1;
        end
        chk("latency", 32'(k), 32'(exp_lat));
        chk("as_delay", 32'(as_k), 32'(SETUP + 1));
        chk("ds_after_as", 32'(ds_k - as_k), 32'd1);
        chk("ds_len", 32'(ds_n), 32'(exp_ds));
        chk("result", bus.vme_dat_reg_out, exp_res);
        chk("hold_stable", {31'd0, unstable}, 32'd0);
        chk("dir_stable", {31'd0, wr_bad}, 32'd0);
        if (rd) chk("read_oe", {31'd0, oe_bad}, 32'd0);
        tick();
        chk("single_pulse", {31'd0, bus.vme_dat_wr}, 32'd0);
        chk("cmd_rd_back", {31'd0, bus.vme_cmd_rd}, 32'd1);
        chk("oe_after", {31'd0, bus.vme_data_oe}, 32'd0);
    endtask

    task automatic back_to_back();
        logic [31:0] c[3], dv[3], er[3];
        int idx, pulses, as_falls, gap, min_gap, k;
        bit acc, prev_as;
        c[0] = 32'h0100_0002; dv[0] = 32'h0000_1111; er[0] = 32'h0000_1111;
        c[1] = 32'h0200_0004; dv[1] = 32'h0000_FFFF; er[1] = 32'h0000_5A5A;
        c[2] = 32'h0000_0006; dv[2] = 32'h0000_2222; er[2] = 32'h0000_2222;
        rsp_mode = 0; rsp_delay = 1; rsp_data = 16'h5A5A;
        wait_ready();
        idx = 0; pulses = 0; as_falls = 0; gap = 0; min_gap = 1000; prev_as = 1;
        bus.start = 1'b1; bus.vme_cmd_reg = c[0]; bus.vme_dat_reg_in = dv[0];
        for (k = 0; k < 80; k++) begin
            acc = bus.vme_cmd_rd && bus.start;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    bus.vme_cmd_reg = c[idx];
                    bus.vme_dat_reg_in = dv[idx];
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (bus.vme_dat_wr) begin
                if (pulses < 3) chk("b2b_result", bus.vme_dat_reg_out, er[pulses]);
                pulses++;
            end
            if (bus.vme_as_b == 1'b0 && prev_as) begin
                as_falls++;
                if (as_falls > 1 && gap < min_gap) min_gap = gap;
            end
            if (bus.vme_as_b) gap++;
            else gap = 0;
            prev_as = bus.vme_as_b;
        end
        chk("b2b_cycles", 32'(as_falls), 32'd3);
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_as_gap", {31'd0, min_gap >= 1}, 32'd1);
    endtask

    task automatic reset_mid_cycle();
        int pulses;
        rsp_mode = 3;
        wait_ready();
        bus.start = 1'b1; bus.vme_cmd_reg = 32'h0100_0010; bus.vme_dat_reg_in = 32'h0000_00AA;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        chk("pre_reset_pins", {27'd0, pins()}, 32'b00001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_pins", {27'd0, pins()}, 32'b11110);
        chk("reset_dat_wr", {31'd0, bus.vme_dat_wr}, 32'd0);
        rsp_mode = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("reset_dat_reg_out", bus.vme_dat_reg_out, 32'd0);
        tick();
        chk("post_reset_cmd_rd", {31'd0, bus.vme_cmd_rd}, 32'd1);
        pulses = 0;
        repeat (10) begin
            if (bus.vme_dat_wr) pulses++;
            tick();
        end
        chk("post_reset_no_pulse", 32'(pulses), 32'd0);
    endtask

    initial begin
        bus.start          = 1'b0;
        bus.vme_cmd_reg    = 32'd0;
        bus.vme_dat_reg_in = 32'd0;
        repeat (3) tick();
        chk("rst_pins", {27'd0, pins()}, 32'b11110);
        chk("rst_cmd_rd", {31'd0, bus.vme_cmd_rd}, 32'd0);
        chk("rst_dat_wr", {31'd0, bus.vme_dat_wr}, 32'd0);
        chk("rst_addr", {9'd0, bus.vme_addr}, 32'd0);
        chk("rst_data_out", {16'd0, bus.vme_data_out}, 32'd0);
        chk("rst_dat_reg_out", bus.vme_dat_reg_out, 32'd0);
        chk("rst_am", {26'd0, bus.vme_am}, 32'h39);
        rst_n = 1'b1;
        tick();
        chk("first_cmd_rd", {31'd0, bus.vme_cmd_rd}, 32'd1);

        run_cmd(32'h01A8_0020, 32'h0000_BEEF, 3, 0, 16'h0000);
        run_cmd(32'h02A8_4100, 32'h0000_0000, 1, 0, 16'h1234);
        run_cmd(32'h02A8_4100, 32'h0000_0000, 2, 1, 16'h7777);
        run_cmd(32'h0312_3456, 32'h0000_CAFE, 1, 2, 16'h4321);
        run_cmd(32'h0300_0ABC, 32'h0000_CAFE, 2, 0, 16'h4321);
        run_cmd(32'h0055_AAAA, 32'h1234_9876, 1, 0, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            run_cmd($urandom, $urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
                    16'($urandom));
        end
`ifdef VME_TIMEOUT_EN
        run_cmd(32'h0200_1000, 32'h0000_0000, 1, 3, 16'h0000);
        run_cmd(32'h0100_2000, 32'h0000_5555, 1, 3, 16'h0000);
`endif
        back_to_back();
        reset_mid_cycle();
        run_cmd(32'h0200_0040, 32'h0000_0000, 1, 0, 16'hA5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
